// File: rtl/data_ram_arbiter_ll.sv
// Two-master arbiter in front of the single-port data RAM.
// M0 is the CPU memory stage (with LL/SC), M1 is the DMA/debug port.
// Holds the LL/SC link reservation and a one-entry response pipeline so
// every accepted transfer answers exactly one cycle after its grant.
module data_ram_arbiter_ll #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter bit          RR = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    // M0: CPU memory stage
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic            m0_ll,
    input  logic            m0_sc,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW/8-1:0] m0_sel,
    input  logic [DW-1:0]   m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_sc_ok,
    // M1: DMA/debug
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW/8-1:0] m1_sel,
    input  logic [DW-1:0]   m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,
    // Reservation flush (exception/eret)
    input  logic            llbit_clr,
    // RAM port
    output logic            ram_ce,
    output logic            ram_we,
    output logic [AW-1:0]   ram_addr,
    output logic [DW/8-1:0] ram_sel,
    output logic [DW-1:0]   ram_wdata,
    input  logic [DW-1:0]   ram_rdata
);

    localparam int unsigned SW = DW / 8;

    // Response owner for the next cycle
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RESP0 = 2'd1;
    localparam logic [1:0] RESP1 = 2'd2;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    logic [1:0]    state_q, state_d;
    logic          last_gnt_q;
    logic          link_valid_q;
    logic [AW-3:0] link_addr_q;
    logic          rd_q, rd_d;
    logic          sc_ok_q;

    logic gnt0, gnt1;
    logic m0_is_ll, m0_is_sc;
    logic sc_ok, sc_fail;
    logic m1_conflict;

    // Byte-offset bits never take part in word compares
    logic unused_ok;
    assign unused_ok = ^{m0_addr[1:0], m1_addr[1:0]};

    // Arbitration: combinational from the requests, one-hot at most
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                if (RR && (last_gnt_q == M0)) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    // Request decode and SC outcome from the pre-edge reservation
    always_comb begin
        m0_is_ll    = m0_ll;
        m0_is_sc    = m0_sc & ~m0_ll;
        sc_ok       = link_valid_q && (m0_addr[AW-1:2] == link_addr_q);
        sc_fail     = m0_is_sc & ~sc_ok;
        m1_conflict = gnt1 & m1_we & (m1_addr[AW-1:2] == link_addr_q);
    end

    // RAM mux; a failing SC gets the grant but never touches the RAM
    always_comb begin
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_sel   = '0;
        ram_wdata = '0;
        rd_d      = 1'b0;
        if (gnt0) begin
            ram_ce    = ~sc_fail;
            ram_we    = m0_we & ~m0_is_ll & ~sc_fail;
            ram_addr  = m0_addr;
            ram_sel   = m0_sel;
            ram_wdata = m0_wdata;
            rd_d      = m0_is_ll | (~m0_we & ~m0_is_sc);
        end else if (gnt1) begin
            ram_ce    = 1'b1;
            ram_we    = m1_we;
            ram_addr  = m1_addr;
            ram_sel   = m1_sel;
            ram_wdata = m1_wdata;
            rd_d      = ~m1_we;
        end
    end

    // Next response owner follows the grant
    always_comb begin
        state_d = IDLE;
        if (gnt0) begin
            state_d = RESP0;
        end else if (gnt1) begin
            state_d = RESP1;
        end
    end

    // Response pipeline and round-robin history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_q       <= 1'b0;
            sc_ok_q    <= 1'b0;
            last_gnt_q <= M1;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            sc_ok_q <= gnt0 & m0_is_sc & sc_ok;
            if (gnt0) begin
                last_gnt_q <= M0;
            end else if (gnt1) begin
                last_gnt_q <= M1;
            end
        end
    end

    // Reservation: flush beats M1 conflict beats SC clear beats LL set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            if (llbit_clr || m1_conflict || (gnt0 && m0_is_sc)) begin
                link_valid_q <= 1'b0;
            end else if (gnt0 && m0_is_ll) begin
                link_valid_q <= 1'b1;
            end
            if (gnt0 && m0_is_ll) begin
                link_addr_q <= m0_addr[AW-1:2];
            end
        end
    end

    // Response outputs; write responses carry zero data
    always_comb begin
        m0_gnt    = gnt0;
        m1_gnt    = gnt1;
        m0_rvalid = (state_q == RESP0);
        m1_rvalid = (state_q == RESP1);
        m0_rdata  = (m0_rvalid && rd_q) ? ram_rdata : {DW{1'b0}};
        m1_rdata  = (m1_rvalid && rd_q) ? ram_rdata : {DW{1'b0}};
        m0_sc_ok  = m0_rvalid & sc_ok_q;
    end

endmodule
